// File: rtl/link_pkg.sv
// Shared states, frame header mapping and default timing constants for the
// telemetry link scheduler.
package link_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PICK       = 3'd1,
    SEND       = 3'd2,
    WAIT_TX    = 3'd3,
    WAIT_REPLY = 3'd4
  } link_state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] ftype;
  } frame_hdr_t;

  localparam int unsigned DEF_REPLY_TIMEOUT = 2500000;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  function automatic frame_hdr_t ch_to_hdr(input logic [3:0] ch);
    frame_hdr_t hdr;
    hdr.mode  = ch[3:2];
    hdr.ftype = ch[1:0];
    return hdr;
  endfunction

endpackage

// File: rtl/link_scheduler_rr_pick.sv
// Round-robin first-set search over the pending mask, starting at ptr and
// wrapping at N_CH; indices at or above N_CH can never be granted.
module rr_pick #(
  parameter int unsigned N_CH = 8
) (
  input  logic [N_CH-1:0] pending,
  input  logic [3:0]      ptr,
  output logic [3:0]      grant,
  output logic            any
);

  logic [15:0] pend_ext;
  logic [4:0]  raw;
  logic [4:0]  idx;
  logic        hit;
  logic        found;

  // Walk the channels from ptr onwards; the first pending one wins.
  always_comb begin
    pend_ext             = 16'd0;
    pend_ext[N_CH-1:0]   = pending;
    grant                = 4'd0;
    found                = 1'b0;
    raw                  = 5'd0;
    idx                  = 5'd0;
    hit                  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      raw   = {1'b0, ptr} + 5'(k);
      idx   = (raw >= 5'(N_CH)) ? (raw - 5'(N_CH)) : raw;
      hit   = !found && pend_ext[idx[3:0]];
      grant = hit ? idx[3:0] : grant;
      found = found | hit;
    end
    any = found;
  end

endmodule

// File: rtl/link_scheduler.sv
// Change-driven round-robin scheduler for the telemetry link with reply timeout
// and bounded retry. Define LINK_SCHED_REFRESH_EN to add periodic forced resends.
module link_scheduler
  import link_pkg::*;
#(
  parameter int unsigned N_CH          = 8,
  parameter int unsigned REPLY_TIMEOUT = DEF_REPLY_TIMEOUT,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
`ifdef LINK_SCHED_REFRESH_EN
  , parameter int unsigned REFRESH_CYCLES = 100000000
`endif
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 link_en,
  input  logic [N_CH*16-1:0]   ch_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [1:0]           tx_mode,
  output logic [1:0]           tx_type,
  output logic [15:0]          tx_payload,
  input  logic                 tx_done,
  input  logic                 reply_valid,
  input  logic                 reply_ok,
  output logic                 busy,
  output logic [3:0]           cur_ch,
  output logic [7:0]           drop_cnt
);

  link_state_t         state;
  logic [N_CH-1:0]     pending;
  logic [N_CH-1:0]     chg;
  logic [N_CH-1:0]     clr;
  logic [N_CH-1:0]     refresh_set;
  logic [N_CH*16-1:0]  prev;
  logic [3:0]          ptr;
  logic [3:0]          ptr_next;
  logic [3:0]          grant;
  logic                any;
  logic [7:0]          retry;
  logic [31:0]         tmo;
  logic [15:0]         pick_word;
  frame_hdr_t          hdr;
  logic                reply_pass;
  logic                reply_fail;
  logic                retire;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .grant   (grant),
    .any     (any)
  );

  // Frame-end events, change mask, and the word/header of the granted channel.
  always_comb begin
    reply_pass = (state == WAIT_REPLY) && reply_valid && reply_ok;
    reply_fail = (state == WAIT_REPLY) &&
                 ((reply_valid && !reply_ok) || (!reply_valid && (tmo == 32'd0)));
    retire     = reply_pass || (reply_fail && (retry == 8'(MAX_RETRY)));
    ptr_next   = (cur_ch == 4'(N_CH - 1)) ? 4'd0 : (cur_ch + 4'd1);
    chg        = {N_CH{1'b0}};
    clr        = {N_CH{1'b0}};
    pick_word  = 16'd0;
    for (int i = 0; i < N_CH; i++) begin
      chg[i]    = ch_data[16*i +: 16] != prev[16*i +: 16];
      clr[i]    = retire && (cur_ch == 4'(i));
      pick_word = (grant == 4'(i)) ? ch_data[16*i +: 16] : pick_word;
    end
    hdr = ch_to_hdr(grant);
  end

`ifdef LINK_SCHED_REFRESH_EN
  logic [31:0] refresh_cnt;
  logic        refresh_wrap;

  assign refresh_wrap = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
  assign refresh_set  = {N_CH{refresh_wrap}};

  // Free-running refresh period counter.
  always_ff @(posedge clk) begin
    if (!nrst || !link_en) begin
      refresh_cnt <= 32'd0;
    end else if (refresh_wrap) begin
      refresh_cnt <= 32'd0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end
`else
  assign refresh_set = {N_CH{1'b0}};
`endif

  // Change-detect copy and pending bits; a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    prev <= ch_data;
    if (!nrst || !link_en) begin
      pending <= {N_CH{1'b1}};
    end else begin
      pending <= (pending & ~clr) | chg | refresh_set;
    end
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst || !link_en) begin
      state      <= IDLE;
      ptr        <= 4'd0;
      retry      <= 8'd0;
      tmo        <= 32'd0;
      tx_valid   <= 1'b0;
      tx_mode    <= 2'd0;
      tx_type    <= 2'd0;
      tx_payload <= 16'd0;
      busy       <= 1'b0;
      cur_ch     <= 4'd0;
      drop_cnt   <= nrst ? drop_cnt : 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= PICK;
            busy  <= 1'b1;
          end
        end
        PICK: begin
          cur_ch     <= grant;
          tx_payload <= pick_word;
          tx_mode    <= hdr.mode;
          tx_type    <= hdr.ftype;
          retry      <= 8'd0;
          tx_valid   <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            tmo   <= 32'(REPLY_TIMEOUT - 1);
            state <= WAIT_REPLY;
          end
        end
        WAIT_REPLY: begin
          if (retire) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            if (!reply_pass && (drop_cnt != 8'hFF)) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end else if (reply_fail) begin
            retry    <= retry + 8'd1;
            tx_valid <= 1'b1;
            state    <= SEND;
          end else begin
            tmo <= tmo - 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_scheduler.sv
// Bench for link_scheduler: a frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_link_scheduler;

  localparam int N  = 8;
  localparam int RT = 10;
  localparam int MR = 3;

  localparam int P_IDLE = 0, P_PICK = 1, P_SEND = 2, P_WAIT_TX = 3, P_WAIT_REPLY = 4;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            link_en = 1'b0;
  logic [N*16-1:0] ch_data;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic [1:0]      tx_mode;
  logic [1:0]      tx_type;
  logic [15:0]     tx_payload;
  logic            tx_done = 1'b0;
  logic            reply_valid = 1'b0;
  logic            reply_ok = 1'b0;
  logic            busy;
  logic [3:0]      cur_ch;
  logic [7:0]      drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  link_scheduler #(.N_CH(N), .REPLY_TIMEOUT(RT), .MAX_RETRY(MR)) dut (
    .clk(clk), .nrst(nrst), .link_en(link_en), .ch_data(ch_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_mode(tx_mode), .tx_type(tx_type),
    .tx_payload(tx_payload), .tx_done(tx_done), .reply_valid(reply_valid),
    .reply_ok(reply_ok), .busy(busy), .cur_ch(cur_ch), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          live = 1'b0;
  int          cycle = 0;
  int          phase, ptr_m, attempts, deadline, g, c, outcome, fin;
  bit          pend[N];
  bit          chg[N];
  logic [15:0] prev_m[N];
  bit          e_valid, e_busy;
  int          e_mode, e_type, e_payload, e_cur, e_drop;

  always @(posedge clk) begin
    cycle++;
    if (!nrst || !link_en) begin
      for (int i = 0; i < N; i++) begin
        pend[i]   = 1'b1;
        prev_m[i] = ch_data[16*i +: 16];
      end
      ptr_m = 0; phase = P_IDLE; attempts = 0; deadline = 0;
      e_valid = 1'b0; e_busy = 1'b0; e_mode = 0; e_type = 0; e_payload = 0; e_cur = 0;
      if (!nrst) e_drop = 0;
      live = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        chg[i]    = (ch_data[16*i +: 16] != prev_m[i]);
        prev_m[i] = ch_data[16*i +: 16];
      end
      fin = -1;
      case (phase)
        P_IDLE: begin
          for (int i = 0; i < N; i++) if (pend[i]) phase = P_PICK;
        end
        P_PICK: begin
          g = -1;
          for (int k = 0; k < N; k++) begin
            c = (ptr_m + k) % N;
            if (g < 0 && pend[c]) g = c;
          end
          e_cur = g; e_payload = int'(ch_data[16*g +: 16]);
          e_mode = (g / 4) % 4; e_type = g % 4;
          attempts = 0; e_valid = 1'b1; phase = P_SEND;
        end
        P_SEND: if (tx_ready) begin e_valid = 1'b0; phase = P_WAIT_TX; end
        P_WAIT_TX: if (tx_done) begin deadline = cycle + RT; phase = P_WAIT_REPLY; end
        P_WAIT_REPLY: begin
          outcome = 0;
          if (reply_valid) outcome = reply_ok ? 1 : 2;
          else if (cycle == deadline) outcome = 2;
          if (outcome == 1) fin = e_cur;
          else if (outcome == 2) begin
            if (attempts < MR) begin attempts++; e_valid = 1'b1; phase = P_SEND; end
            else begin fin = e_cur; if (e_drop < 255) e_drop++; end
          end
          if (fin >= 0) begin ptr_m = (fin + 1) % N; phase = P_IDLE; end
        end
        default: phase = P_IDLE;
      endcase
      if (fin >= 0) pend[fin] = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = pend[i] | chg[i];
      e_busy = (phase != P_IDLE);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("tx_valid",   32'(tx_valid),   32'(e_valid));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("tx_mode",    32'(tx_mode),    32'(e_mode));
      chk("tx_type",    32'(tx_type),    32'(e_type));
      chk("tx_payload", 32'(tx_payload), 32'(e_payload));
      chk("cur_ch",     32'(cur_ch),     32'(e_cur));
      chk("drop_cnt",   32'(drop_cnt),   32'(e_drop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic set_ch(input int ch, input logic [15:0] v); ch_data[16*ch +: 16] = v; endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 50) begin cyc(); n++; end
    chk("tx_valid_arrives", 32'(tx_valid), 32'd1);
  endtask
  task automatic hs(); tx_ready = 1'b1; cyc(); tx_ready = 1'b0; endtask
  task automatic done(); tx_done = 1'b1; cyc(); tx_done = 1'b0; endtask
  task automatic rep(input bit ok);
    reply_valid = 1'b1; reply_ok = ok; cyc(); reply_valid = 1'b0; reply_ok = 1'b0;
  endtask
  task automatic serve(input bit ok, input int exp_ch);
    int n;
    wait_valid(n);
    chk("serve_ch", 32'(cur_ch), 32'(exp_ch));
    hs(); done(); rep(ok);
  endtask

  int wn;
  initial begin
    for (int i = 0; i < N; i++) set_ch(i, 16'(16'h1000 + i));
    nrst = 1'b0; link_en = 1'b1;
    cyc(); cyc();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);
    chk("rst_cur_ch",   32'(cur_ch),   32'd0);
    nrst = 1'b1;
    for (int i = 0; i < N; i++) serve(1'b1, i);
    cyc();
    chk("idle_after_drain", 32'(busy), 32'd0);

    // single change on channel 5
    set_ch(5, 16'hABCD);
    wait_valid(wn);
    chk("change_latency", 32'(wn), 32'd3);
    chk("ch5_payload", 32'(tx_payload), 32'h0000ABCD);
    chk("ch5_mode", 32'(tx_mode), 32'd1);
    chk("ch5_type", 32'(tx_type), 32'd1);
    chk("ch5_cur", 32'(cur_ch), 32'd5);
    hs(); done(); rep(1'b1);
    repeat (4) cyc();
    chk("single_frame_only", 32'(busy), 32'd0);

    // four bad replies on channel 6 -> drop
    set_ch(6, 16'h1234);
    for (int a = 0; a <= MR; a++) begin
      wait_valid(wn);
      chk("retry_cur", 32'(cur_ch), 32'd6);
      chk("retry_payload", 32'(tx_payload), 32'h00001234);
      hs(); done(); rep(1'b0);
    end
    chk("drop_count", 32'(drop_cnt), 32'd1);
    chk("idle_after_drop", 32'(busy), 32'd0);

    // timeout on channel 2
    set_ch(2, 16'h5A5A);
    wait_valid(wn);
    chk("tmo_cur", 32'(cur_ch), 32'd2);
    hs(); done();
    wn = 0;
    while (!tx_valid && wn < 30) begin cyc(); wn++; end
    chk("timeout_gap", 32'(wn), 32'd10);
    hs(); done(); rep(1'b1);

    // round robin from ptr 3 with pending {1,3,6}
    set_ch(1, 16'h0101); set_ch(3, 16'h0303); set_ch(6, 16'h0606);
    serve(1'b1, 3); serve(1'b1, 6); serve(1'b1, 1);

    // channel 2 changes in the same cycle as its good reply
    set_ch(2, 16'h0F0F);
    wait_valid(wn);
    chk("coin_cur_a", 32'(cur_ch), 32'd2);
    hs(); done();
    set_ch(2, 16'hF0F0);
    rep(1'b1);
    wait_valid(wn);
    chk("coin_cur_b", 32'(cur_ch), 32'd2);
    chk("coin_payload", 32'(tx_payload), 32'h0000F0F0);
    hs(); done(); rep(1'b1);

    // reply on the timeout cycle wins
    set_ch(4, 16'h4444);
    wait_valid(wn);
    hs(); done();
    repeat (RT - 1) cyc();
    rep(1'b1);
    chk("reply_at_tmo_busy", 32'(busy), 32'd0);
    chk("reply_at_tmo_valid", 32'(tx_valid), 32'd0);

    // link_en drop while in SEND
    set_ch(7, 16'h7777);
    wait_valid(wn);
    link_en = 1'b0;
    cyc();
    chk("linkoff_valid", 32'(tx_valid), 32'd0);
    chk("linkoff_drop", 32'(drop_cnt), 32'd1);
    link_en = 1'b1;
    for (int i = 0; i < N; i++) serve(1'b1, i);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      tx_ready    = ($urandom % 2) == 1;
      tx_done     = ($urandom % 5) == 0;
      reply_valid = ($urandom % 10) == 0;
      reply_ok    = ($urandom % 2) == 1;
      if (($urandom % 16) == 0) set_ch(int'($urandom % N), 16'($urandom));
      link_en     = ($urandom % 400) != 0;
      nrst        = (k != 2000);
      cyc();
    end
    tx_ready = 1'b0; tx_done = 1'b0; reply_valid = 1'b0; link_en = 1'b1; nrst = 1'b1;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/link_scheduler.md
# link_scheduler

Sequences the bit-serial SWIPT telemetry link: picks which 16-bit status word goes out next, hands it to the frame serializer, and waits for the ground-station reply with timeout and bounded retry. It sits between the telemetry sources (P_TX, duty, frequency, heights, comms counters, …) and the framer/reply analyser. It replaces the fixed field cycling with change-driven round-robin scheduling.

## Interface
- N_CH, 8: number of telemetry channels (2..16).
- REPLY_TIMEOUT, 2500000: cycles to wait for a reply after tx_done (25 ms at 100 MHz).
- MAX_RETRY, 3: retransmissions after the first attempt before a frame is dropped.
- REFRESH_CYCLES, 100000000: forced-refresh period (only with the refresh macro).
- clk  in  1  clock.
- nrst  in  1  synchronous, active-low reset.
- link_en  in  1  link enable (swiptAlive && program==3); low acts as a soft reset.
- ch_data  in  N_CH*16  flattened channel words; channel i is [16i+15:16i].
- tx_valid  out  1  frame request to the framer.
- tx_ready  in  1  framer accepts the request.
- tx_mode  out  2  frame mode field.
- tx_type  out  2  frame type field.
- tx_payload  out  16  frame data.
- tx_done  in  1  one-cycle pulse when the last frame bit has been shifted out.
- reply_valid  in  1  one-cycle pulse when the reply analyser has a decoded reply.
- reply_ok  in  1  reply checksum/ack is good; sampled with reply_valid.
- busy  out  1  state is not IDLE.
- cur_ch  out  4  channel currently owned.
- drop_cnt  out  8  number of dropped frames, saturating at 255.

## Operation
- States:
  - IDLE: if any pending bit is set, go to PICK.
  - PICK: grant the first pending channel at or after ptr (wrap-around search); latch payload, mode and type; clear the retry count; go to SEND.
  - SEND: hold tx_valid until the tx_valid&&tx_ready handshake, then go to WAIT_TX.
  - WAIT_TX: on tx_done, load the timeout counter and go to WAIT_REPLY.
  - WAIT_REPLY:
    - reply_valid && reply_ok: success.
    - reply_valid && !reply_ok, or timeout expired: failure.
- Success: clear pending[cur_ch], set ptr = cur_ch+1 modulo N_CH, go to IDLE.
- Failure with retry < MAX_RETRY: retry += 1, go back to SEND with the same latched payload.
- Failure with retry == MAX_RETRY: treat as a drop.
  - drop_cnt += 1 (saturating), clear pending, advance ptr, go to IDLE.
- Pending bits:
  - pending[i] is set when ch_data[i] differs from its previous-cycle copy.
  - If a set and a clear hit the same channel in the same cycle, set wins, so the new value is resent later.
- Payload is latched at PICK and is not affected by later ch_data changes.
- Mode/type mapping: tx_mode = ch[3:2], tx_type = ch[1:0].
- Unused channel indices (≥ N_CH) are never granted.

## Timing
- Reset (nrst low, or link_en low) in any state, at the next clk edge:
  - state IDLE; ptr 0; retry 0; timeout counter 0.
  - pending set to all ones, so every channel is sent once after enable.
  - tx_valid 0; tx_mode/tx_type/tx_payload 0; busy 0; cur_ch 0.
  - drop_cnt 0 on nrst only; link_en low preserves it.
- Latency from a pending bit seen in IDLE to tx_valid high: 2 cycles (IDLE→PICK→SEND).
- tx_valid is registered. It drops the cycle after the handshake and never deasserts without a handshake.
- Timeout: the counter is loaded with REPLY_TIMEOUT-1 on tx_done and decrements in WAIT_REPLY; failure fires when it is 0 with no reply_valid.
- reply_valid on the same cycle the counter hits 0: the reply takes precedence.
- reply_valid or tx_done outside their wait states: ignored.
- Change-detect copy: resets to the current ch_data value (no spurious set after reset beyond the all-ones init).

## Configuration
- LINK_SCHED_REFRESH_EN defined: a free-running counter of REFRESH_CYCLES sets all pending bits when it wraps, so unchanged values are still re-sent periodically. The counter is reset by nrst and link_en.
- LINK_SCHED_REFRESH_EN undefined: pending bits are set only by reset and data changes; no refresh counter logic is present.

## Structure
- Shared package link_pkg:
  - state enum (IDLE, PICK, SEND, WAIT_TX, WAIT_REPLY).
  - channel-to-mode/type mapping function.
  - default REPLY_TIMEOUT and MAX_RETRY constants.
- Sub-module rr_pick: combinational round-robin first-set search over pending starting at ptr; outputs grant index and any-valid flag.

## Test plan
- Single change: after reset, drain the initial sends, then change ch 5 to 16'hABCD; reply ok → exactly one frame with mode=1, type=1, payload ABCD; pending clears.
- Round-robin: ptr=3 with pending {1,3,6} → grant order 3, 6, 1.
- Retry/drop: MAX_RETRY=3 and replies always bad → 4 handshakes, then drop_cnt=1 and next channel served.
- Timeout: REPLY_TIMEOUT=10 with no reply → retry begins 10 cycles after tx_done.
- Coincident events:
  - ch 2 changes during its own WAIT_REPLY with ok reply → pending[2] stays set and the new value is sent next.
  - reply_valid on the timeout cycle → counted as a reply.
- Reset mid-frame: drop link_en in SEND → tx_valid 0 next cycle, drop_cnt preserved, all channels resent after re-enable.
